// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the two-port data-memory arbiter: widths, FSM states, latched op encoding.
package dmem_arbiter_pkg;
  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;
  localparam int NUM_PORTS  = 2;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic       {OP_READ, OP_WRITE} op_t;
endpackage

// File: rtl/dmem_arb_pick.sv
// Winner selection between the two requesters.
// DMEM_ARB_ROUND_ROBIN_EN: ties go to the port not granted last; otherwise port 0 wins ties.
module dmem_arb_pick
  import dmem_arbiter_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 take,
  output logic                 win
);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // last granted port; resets to 1 so port 0 takes the first tie
  logic last;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    last <= 1'b1;
    else if (take) last <= win;
  end

  always_comb begin
    win = 1'b0;
    if (req == 2'b10)      win = 1'b1;
    else if (req == 2'b11) win = ~last;
  end
`else
  logic pick_unused;
  assign pick_unused = &{1'b0, clock, reset, take};
  assign win = req[1] & ~req[0];
`endif
endmodule

// File: rtl/dmem_arbiter.sv
// Shares one block memory between two cache ports: latch winner's request, hold it until the
// memory drops busywait, return the block, then idle one cycle. Option: DMEM_ARB_ROUND_ROBIN_EN.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_read,
  input  logic              p0_write,
  input  logic [ADDR_W-1:0] p0_address,
  input  logic [DATA_W-1:0] p0_writedata,
  output logic [DATA_W-1:0] p0_readdata,
  output logic              p0_busywait,
  input  logic              p1_read,
  input  logic              p1_write,
  input  logic [ADDR_W-1:0] p1_address,
  input  logic [DATA_W-1:0] p1_writedata,
  output logic [DATA_W-1:0] p1_readdata,
  output logic              p1_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait
);
  logic [NUM_PORTS-1:0]             req, wr_req, bw;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] addr_in;
  logic [NUM_PORTS-1:0][DATA_W-1:0] wdata_in, rdata_q;
  state_t                           state, state_nx;
  op_t                              op;
  logic                             grant, win, take, cap;
  logic [ADDR_W-1:0]                addr_q;
  logic [DATA_W-1:0]                wdata_q;

  assign req      = {p1_read | p1_write, p0_read | p0_write};
  assign wr_req   = {p1_write, p0_write};
  assign addr_in  = {p1_address, p0_address};
  assign wdata_in = {p1_writedata, p0_writedata};
  assign take     = (state == IDLE) && (|req);
  assign cap      = (state == BUSY) && !mem_busywait && (op == OP_READ);

  dmem_arb_pick u_pick (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .take  (take),
    .win   (win)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state)
      IDLE: if (|req) state_nx = BUSY;
      BUSY: begin
        mem_read  = (op == OP_READ);
        mem_write = (op == OP_WRITE);
        if (!mem_busywait) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // write wins when a port raises read and write together
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grant   <= 1'b0;
      op      <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (take) begin
      grant   <= win;
      op      <= wr_req[win] ? OP_WRITE : OP_READ;
      addr_q  <= addr_in[win];
      wdata_q <= wdata_in[win];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)   rdata_q <= '0;
    else if (cap) rdata_q[grant] <= mem_readdata;
  end

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_bw
    assign bw[i] = req[i] & ~((state == DONE) && (grant == 1'(i)));
  end

  assign mem_address   = addr_q;
  assign mem_writedata = wdata_q;
  assign p0_readdata   = rdata_q[0];
  assign p1_readdata   = rdata_q[1];
  assign p0_busywait   = bw[0];
  assign p1_busywait   = bw[1];
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single block-wide data memory between two cache requesters (instruction cache on port 0, data cache on port 1, or two data caches during cache switching). Each requester sees the same read/write/busywait block interface the memory presents; the arbiter grants one requester at a time, forwards its latched request to the memory and holds it there until the memory drops busywait. It then returns the block to the winner and releases the memory for one cycle before the next grant.

## Interface
- ADDR_W, 28, block address width (byte offset excluded)
- DATA_W, 128, block width in bits
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- p0_read, p1_read  in  1  block read request, held until own busywait low
- p0_write, p1_write  in  1  block write request, held until own busywait low
- p0_address, p1_address  in  ADDR_W  block address
- p0_writedata, p1_writedata  in  DATA_W  write block
- p0_readdata, p1_readdata  out  DATA_W  registered read block per port
- p0_busywait, p1_busywait  out  1  stall to requester
- mem_read, mem_write  out  1  request to memory
- mem_address  out  ADDR_W  latched address to memory
- mem_writedata  out  DATA_W  latched write block to memory
- mem_readdata  in  DATA_W  memory read block
- mem_busywait  in  1  memory stall; low marks the final access cycle

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: if any port has read|write, pick winner (see Configuration), latch grant, op, address, writedata; -> BUSY. Else stay.
- Op latch: write has priority if a port asserts read and write together; exactly one of mem_read/mem_write is ever driven.
- BUSY: mem_read/mem_write from latched op, mem_address/mem_writedata from latch. On an edge with mem_busywait=0: if op=read, capture mem_readdata into winner's readdata register; -> DONE.
- DONE: mem_read=mem_write=0; winner's busywait=0; -> IDLE unconditionally.
- pN_busywait = (pN_read|pN_write) & !(state==DONE & grant==N). Idle port with no request sees busywait=0.
- Loser keeps busywait high; it is considered on the next IDLE cycle.
- Request withdrawn during BUSY: transaction still completes on memory (memory cannot abort); readdata still updated; no other effect.
- Non-granted port's readdata holds its value.

## Timing
- Reset (reset=0): state IDLE, mem_read=mem_write=0, mem_address=0, mem_writedata=0, p0/p1_readdata=0, grant=0, priority pointer=1; busywait outputs follow the combinational rule (state IDLE). The downstream memory is reset on the same reset event; reset mid-BUSY abandons the transaction with no completion.
- Request sampled in IDLE at edge E; mem request asserted from E+1. With a 16-cycle memory (busywait low in its 16th access cycle), capture at E+17, requester busywait low during E+17..E+18 cycle, next grant earliest at E+18 in IDLE, mem request again from E+19.
- General: completion latency = memory access cycles + 1; back-to-back transactions separated by one DONE and one IDLE cycle with memory request low, guaranteeing the memory sees a deasserted request between transactions.
- Latched address/data stable for the entire BUSY span regardless of requester inputs.

## Configuration
- DMEM_ARB_ROUND_ROBIN_EN defined: on simultaneous requests in IDLE, grant the port other than the last granted; pointer updated on each grant, reset value 1 (port 0 wins first tie).
- Not defined: fixed priority, port 0 always wins ties; pointer register absent.

## Structure
- Shared package: ADDR_W/DATA_W defaults, state enum (IDLE, BUSY, DONE), op encoding (OP_READ, OP_WRITE).
- One sub-module: dmem_arb_pick — winner selection from two request lines plus priority pointer; contains the pointer register only when DMEM_ARB_ROUND_ROBIN_EN is defined.

## Test plan
- Reset asserted mid-BUSY -> all outputs to reset values immediately, mem_read/mem_write 0, next request starts fresh with full latency.
- Port 0 read only, memory preloaded 0x00112233_44556677_8899AABB_CCDDEEFF at block 0x3 -> p0_readdata equals it, p0_busywait low exactly one cycle at E+17.
- Port 1 write 0xDEADBEEF... to block 0x2 then port 0 read block 0x2 -> p0_readdata = written value; mem request low for two cycles between transactions.
- Both ports request simultaneously, repeated 4 times -> with macro grants alternate 0,1,0,1; without macro port 0 granted every tie.
- Port asserts read and write together -> only mem_write driven, no deadlock, busywait drops after completion.
- Port 1 changes address during BUSY -> mem_address stays at latched value until DONE.
